// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared widths and FSM encodings for the softmax datapath
package softmax_pkg;

  // Defaults shared with the softmax core and the score FIFO
  localparam int SM_DATA_WIDTH = 16;
  localparam int SM_NUM_CLASS  = 7;
  localparam int SM_IDX_WIDTH  = 3;

  // Argmax reader FSM encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/softmax_argmax_unit_if.sv
// rtl/softmax_argmax_unit_if.sv - control, FIFO read port and result bundle of the argmax unit
interface softmax_argmax_unit_if
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = SM_DATA_WIDTH,
  parameter int IDX_WIDTH  = SM_IDX_WIDTH
);

  logic                  start;
  logic                  fifo_rd_clr;
  logic                  fifo_rd_en;
  logic                  fifo_rd_inc;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  busy;
  logic                  done;
  logic [IDX_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] max_val;

  // The argmax unit itself
  modport slave (
    input  start,
    input  fifo_data,
    output fifo_rd_clr,
    output fifo_rd_en,
    output fifo_rd_inc,
    output busy,
    output done,
    output class_idx,
    output max_val
  );

  // Whoever launches frames and serves the FIFO read port
  modport master (
    output start,
    output fifo_data,
    input  fifo_rd_clr,
    input  fifo_rd_en,
    input  fifo_rd_inc,
    input  busy,
    input  done,
    input  class_idx,
    input  max_val
  );

endinterface

// File: rtl/softmax_max_cmp.sv
// rtl/softmax_max_cmp.sv - signed running-max compare and select
module softmax_max_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 3
) (
  input  logic signed [DATA_WIDTH-1:0] run_max,
  input  logic        [IDX_WIDTH-1:0]  run_idx,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic        [IDX_WIDTH-1:0]  sample_idx,
  input  logic                         first,
  output logic signed [DATA_WIDTH-1:0] next_max,
  output logic        [IDX_WIDTH-1:0]  next_idx
);

  // Strictly greater only, so on a tie the earlier (lower) index is kept
  logic take;

  // First sample of a frame always loads; later ones must beat the running max
  always_comb begin
    take     = first | (sample > run_max);
    next_max = take ? sample     : run_max;
    next_idx = take ? sample_idx : run_idx;
  end

endmodule

// File: rtl/softmax_argmax_unit.sv
// rtl/softmax_argmax_unit.sv - score buffer reader and argmax reducer
module softmax_argmax_unit
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = SM_DATA_WIDTH,
  parameter int NUM_CLASS  = SM_NUM_CLASS,
  parameter int IDX_WIDTH  = SM_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  softmax_argmax_unit_if.slave  bus
);

  // One spare bit so a counter never wraps inside a frame
  localparam int               CNT_WIDTH = IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_CLASS - 1);

  logic [2:0]                   state;
  logic [CNT_WIDTH-1:0]         issue_cnt;
  logic [CNT_WIDTH-1:0]         recv_cnt;
  logic                         rd_vld;

  logic signed [DATA_WIDTH-1:0] run_max;
  logic        [IDX_WIDTH-1:0]  run_idx;
  logic signed [DATA_WIDTH-1:0] next_max;
  logic        [IDX_WIDTH-1:0]  next_idx;

  logic                         rd_clr_q;
  logic                         rd_en_q;
  logic                         rd_inc_q;
  logic                         busy_q;
  logic                         done_q;
  logic        [IDX_WIDTH-1:0]  class_idx_q;
  logic        [DATA_WIDTH-1:0] max_val_q;

  softmax_max_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_max_cmp (
    .run_max    (run_max),
    .run_idx    (run_idx),
    .sample     (bus.fifo_data),
    .sample_idx (recv_cnt[IDX_WIDTH-1:0]),
    .first      (recv_cnt == '0),
    .next_max   (next_max),
    .next_idx   (next_idx)
  );

  // Frame sequencing; every FIFO control and status output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      rd_clr_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_inc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_clr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_CLR;
            rd_clr_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_CLR: begin
          issue_cnt <= '0;
          rd_en_q   <= 1'b1;
          rd_inc_q  <= 1'b1;
          state     <= S_READ;
        end
        S_READ: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == LAST_CNT) begin
            rd_en_q  <= 1'b0;
            rd_inc_q <= 1'b0;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          rd_en_q  <= 1'b0;
          rd_inc_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Read data lands one cycle after the enable; only qualified samples reach the reducer
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      recv_cnt <= '0;
      run_max  <= '0;
      run_idx  <= '0;
    end else begin
      rd_vld <= rd_en_q;
      if (state == S_CLR) begin
        recv_cnt <= '0;
      end else if (rd_vld) begin
        recv_cnt <= recv_cnt + 1'b1;
        run_max  <= next_max;
        run_idx  <= next_idx;
      end
    end
  end

  // Published result changes only when a frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      class_idx_q <= '0;
      max_val_q   <= '0;
    end else if (state == S_DONE) begin
      class_idx_q <= run_idx;
      max_val_q   <= run_max;
    end
  end

  assign bus.fifo_rd_clr = rd_clr_q;
  assign bus.fifo_rd_en  = rd_en_q;
  assign bus.fifo_rd_inc = rd_inc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.max_val     = max_val_q;

endmodule

// File: tb/tb_softmax_argmax_unit.sv
// tb/tb_softmax_argmax_unit.sv - randomized and directed bench for softmax_argmax_unit
module tb_softmax_argmax_unit;

  localparam int DW = 16;
  localparam int NC = 7;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  softmax_argmax_unit_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) sm_if ();

  softmax_argmax_unit #(
    .DATA_WIDTH (DW),
    .NUM_CLASS  (NC),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sm_if)
  );

  // FIFO read port model: registered data, zero when idle, pointer rewound by rd_clr
  logic [DW-1:0] mem [8];
  int ptr = 0;

  always @(posedge clk) begin
    if (sm_if.fifo_rd_clr) ptr <= 0;
    else if (sm_if.fifo_rd_inc) ptr <= ptr + 1;
    sm_if.fifo_data <= sm_if.fifo_rd_en ? mem[ptr % 8] : '0;
  end

  // Event counters, sampled at posedge so they see the values of the finished cycle
  int en_cnt = 0;
  int clr_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (sm_if.fifo_rd_en === 1'b1) en_cnt++;
    if (sm_if.fifo_rd_clr === 1'b1) clr_cnt++;
    if (sm_if.done === 1'b1) done_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first occurrence of the largest signed score
  function automatic void ref_argmax(input int s[NC], output int idx, output int val);
    idx = 0;
    val = s[0];
    for (int i = 1; i < NC; i++) begin
      if (s[i] > val) begin
        val = s[i];
        idx = i;
      end
    end
  endfunction

  task automatic load_mem(input int s[NC]);
    for (int i = 0; i < 8; i++) mem[i] = (i < NC) ? DW'(s[i]) : '0;
  endtask

  // One frame; start is held for 'hold' cycles (hold>1 exercises start-while-busy)
  task automatic run_frame(input string tag, input int s[NC], input int hold);
    int e_idx, e_val, n, en0, clr0, d0;
    load_mem(s);
    ref_argmax(s, e_idx, e_val);
    en0 = en_cnt; clr0 = clr_cnt; d0 = done_cnt;
    @(negedge clk) sm_if.start = 1'b1;
    repeat (hold) @(negedge clk);
    sm_if.start = 1'b0;
    n = hold;
    while (sm_if.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n - 1, NC + 3);
    chk({tag, ".class_idx"}, sm_if.class_idx, e_idx);
    chk({tag, ".max_val"}, int'($signed(sm_if.max_val)), e_val);
    @(negedge clk);
    chk({tag, ".done_pulse"}, sm_if.done, 0);
    chk({tag, ".busy_after"}, sm_if.busy, 0);
    @(negedge clk);
    chk({tag, ".rd_en_cycles"}, en_cnt - en0, NC);
    chk({tag, ".rd_clr_pulses"}, clr_cnt - clr0, 1);
    chk({tag, ".done_count"}, done_cnt - d0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, sm_if.busy, 0);
    chk({tag, ".done"}, sm_if.done, 0);
    chk({tag, ".rd_clr"}, sm_if.fifo_rd_clr, 0);
    chk({tag, ".rd_en"}, sm_if.fifo_rd_en, 0);
    chk({tag, ".rd_inc"}, sm_if.fifo_rd_inc, 0);
    chk({tag, ".class_idx"}, sm_if.class_idx, 0);
    chk({tag, ".max_val"}, sm_if.max_val, 0);
  endtask

  initial begin
    int s[NC];
    int n, n1, en0, clr0, d0;

    rst = 1'b1;
    sm_if.start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    s = '{3, -5, 12, 7, 0, 12, -1};
    run_frame("t1_tie12", s, 1);

    s = '{-4, -4, -4, -4, -4, -4, -4};
    run_frame("t2_all_neg4", s, 1);
    chk("t2.raw_bits", sm_if.max_val, 16'hFFFC);

    s = '{-9, -8, -7, -6, -5, -4, -32768};
    run_frame("t3_all_neg", s, 1);

    // Reset during the third read issue
    s = '{5, 1, 2, 3, 4, 6, 0};
    load_mem(s);
    @(negedge clk) sm_if.start = 1'b1;
    @(negedge clk) sm_if.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4.reading", sm_if.fifo_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("t4.mid_rst");
    rst = 1'b0;
    s = '{1, 9, 2, 9, 3, 4, -2};
    run_frame("t4_after_rst", s, 1);

    // Back-to-back frames with start held high
    s = '{1, 2, 3, 4, 5, 6, 7};
    load_mem(s);
    en0 = en_cnt; clr0 = clr_cnt; d0 = done_cnt;
    @(negedge clk) sm_if.start = 1'b1;
    n = 0;
    while (sm_if.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n1 = n;
    chk("t5.first_latency", n1 - 1, NC + 3);
    chk("t5.first_idx", sm_if.class_idx, 6);
    chk("t5.first_val", int'($signed(sm_if.max_val)), 7);
    s = '{7, 6, 5, 4, 3, 2, 1};
    load_mem(s);
    @(negedge clk);
    n++;
    sm_if.start = 1'b0;
    while (sm_if.done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("t5.done_spacing", n - n1, NC + 4);
    chk("t5.second_idx", sm_if.class_idx, 0);
    chk("t5.second_val", int'($signed(sm_if.max_val)), 7);
    repeat (2) @(negedge clk);
    chk("t5.rd_clr_pulses", clr_cnt - clr0, 2);
    chk("t5.rd_en_cycles", en_cnt - en0, 2 * NC);
    chk("t5.done_count", done_cnt - d0, 2);

    // start kept high while busy must not retrigger or stretch the frame
    s = '{-3, 8, -100, 8, 2, 0, 1};
    run_frame("t6_start_busy", s, 6);

    // Randomized frames; odd frames draw from a narrow range to force ties
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < NC; i++) begin
        if (f % 2 == 1) s[i] = int'($urandom_range(0, 6)) - 3;
        else s[i] = int'($signed(16'($urandom())));
      end
      run_frame($sformatf("rand%0d", f), s, 1 + int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
